// File: rtl/dcpu_bus_pkg.sv
// Shared types and constants for the dcpu bus arbiter.
// The optional ack watchdog is enabled by defining DCPU_ARB_TIMEOUT_EN.
package dcpu_bus_pkg;

    localparam int DCPU_BUS_AW = 16;
    localparam int DCPU_BUS_DW = 16;

    // Master indices: M0 = dcpu core, M1 = DMA/debug loader.
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Read data returned to a master whose transfer was forcibly aborted.
    localparam logic [15:0] DCPU_BUS_ERR_DAT = 16'hDEAD;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } arb_state_e;

    // Watchdog counter width: enough to reach the timeout, kept within 8..16 bits.
    function automatic int watchdog_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        if (w < 8) w = 8;
        if (w > 16) w = 16;
        return w;
    endfunction

endpackage

// File: rtl/dcpu_bus_watchdog.sv
// Ack watchdog for the dcpu bus arbiter: counts cycles a granted request
// waits for the slave and pulses 'fire' on the TIMEOUT-th waiting cycle.
// Only instantiated when DCPU_ARB_TIMEOUT_EN is defined.
module dcpu_bus_watchdog
    import dcpu_bus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting,
    output logic fire
);

    localparam int CW = watchdog_width(TIMEOUT);

    logic [CW-1:0] count;

    // Cycle number 'count+1' of the current wait; fire on the last allowed one.
    assign fire = waiting && (count == CW'(TIMEOUT - 1));

    // Count consecutive waiting cycles; any break in waiting or a fire restarts.
    always_ff @(posedge clk) begin
        if (reset || !waiting || fire) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/dcpu_bus_arbiter.sv
// Two-master arbiter for the dcpu memory bus (M0 = core, M1 = DMA/debug).
// Registered grant with round-robin per completed transfer; once granted,
// address/data/ack paths are combinational.
// Optional ack timeout is enabled by defining DCPU_ARB_TIMEOUT_EN.
//
// Handshake: a master holds cs high (with stable addr/dat/we) until it sees
// its ack; the cycle with ack high completes the transfer. Dropping cs
// before ack abandons the request. The slave sees cs only from the owner.
module dcpu_bus_arbiter
    import dcpu_bus_pkg::*;
#(
    parameter int AW      = DCPU_BUS_AW,
    parameter int DW      = DCPU_BUS_DW,
    parameter int TIMEOUT = 255
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [AW-1:0] i_m0_addr,
    input  logic [AW-1:0] i_m1_addr,
    input  logic [DW-1:0] i_m0_dat,
    input  logic [DW-1:0] i_m1_dat,
    input  logic          i_m0_we,
    input  logic          i_m1_we,
    input  logic          i_m0_cs,
    input  logic          i_m1_cs,
    output logic [DW-1:0] o_m0_dat,
    output logic [DW-1:0] o_m1_dat,
    output logic          o_m0_ack,
    output logic          o_m1_ack,
    output logic [AW-1:0] o_s_addr,
    output logic [DW-1:0] o_s_dat,
    output logic          o_s_we,
    output logic          o_s_cs,
    input  logic [DW-1:0] i_s_dat,
    input  logic          i_s_ack,
    output logic          o_timeout
);

    arb_state_e state, state_next;
    logic       last_served, last_served_next;
    logic       granted, owner, own_cs, other_cs, own_ack, done, timeout_fire;

    // Reset gates the bus in the same cycle so a pending transfer is dropped.
    assign granted  = (state != IDLE) && !i_reset;
    assign owner    = (state == G1) ? M1 : M0;
    assign own_cs   = (owner == M1) ? i_m1_cs : i_m0_cs;
    assign other_cs = (owner == M1) ? i_m0_cs : i_m1_cs;
    assign own_ack  = granted && own_cs && i_s_ack;
    assign done     = own_ack || timeout_fire;

`ifdef DCPU_ARB_TIMEOUT_EN
    logic waiting;
    assign waiting = granted && own_cs && !i_s_ack;

    dcpu_bus_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (i_clk),
        .reset  (i_reset),
        .waiting(waiting),
        .fire   (timeout_fire)
    );
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_fire   = 1'b0;
`endif

    assign o_timeout = timeout_fire;

    // Grant and round-robin pointer registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            last_served <= M1;
        end else begin
            state       <= state_next;
            last_served <= last_served_next;
        end
    end

    // Next grant: arbitrate from IDLE, hand over on completion, release on abort.
    always_comb begin
        state_next       = state;
        last_served_next = last_served;
        case (state)
            IDLE: begin
                if (i_m0_cs && i_m1_cs) begin
                    state_next = (last_served == M1) ? G0 : G1;
                end else if (i_m0_cs) begin
                    state_next = G0;
                end else if (i_m1_cs) begin
                    state_next = G1;
                end
            end
            G0, G1: begin
                if (done) begin
                    last_served_next = owner;
                    if (other_cs) begin
                        state_next = (owner == M1) ? G0 : G1;
                    end else if (!own_cs) begin
                        state_next = IDLE;
                    end
                end else if (!own_cs) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus muxes: owner drives the slave; read data fans out, ack qualifies it.
    always_comb begin
        o_s_addr = '0;
        o_s_dat  = '0;
        o_s_we   = 1'b0;
        o_s_cs   = 1'b0;
        if (granted) begin
            o_s_addr = (owner == M1) ? i_m1_addr : i_m0_addr;
            o_s_dat  = (owner == M1) ? i_m1_dat  : i_m0_dat;
            o_s_we   = (owner == M1) ? i_m1_we   : i_m0_we;
            o_s_cs   = own_cs && !timeout_fire;
        end
        o_m0_ack = done && (owner == M0);
        o_m1_ack = done && (owner == M1);
        o_m0_dat = (timeout_fire && owner == M0) ? DW'(DCPU_BUS_ERR_DAT) : i_s_dat;
        o_m1_dat = (timeout_fire && owner == M1) ? DW'(DCPU_BUS_ERR_DAT) : i_s_dat;
    end

endmodule

// File: tb/tb_dcpu_bus_arbiter.sv
// Testbench for dcpu_bus_arbiter: directed scenarios followed by randomized
// traffic, checked cycle by cycle against a transfer-level reference model.
module tb_dcpu_bus_arbiter;

    localparam int AW      = 16;
    localparam int DW      = 16;
    localparam int TIMEOUT = 4;
`ifdef DCPU_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [AW-1:0] m0_addr, m1_addr, s_addr;
    logic [DW-1:0] m0_wdat, m1_wdat, m0_rdat, m1_rdat, s_wdat, s_rdat;
    logic          m0_we, m1_we, m0_cs, m1_cs, m0_ack, m1_ack;
    logic          s_we, s_cs, s_ack, timeout;

    dcpu_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_m0_addr(m0_addr),
        .i_m1_addr(m1_addr),
        .i_m0_dat (m0_wdat),
        .i_m1_dat (m1_wdat),
        .i_m0_we  (m0_we),
        .i_m1_we  (m1_we),
        .i_m0_cs  (m0_cs),
        .i_m1_cs  (m1_cs),
        .o_m0_dat (m0_rdat),
        .o_m1_dat (m1_rdat),
        .o_m0_ack (m0_ack),
        .o_m1_ack (m1_ack),
        .o_s_addr (s_addr),
        .o_s_dat  (s_wdat),
        .o_s_we   (s_we),
        .o_s_cs   (s_cs),
        .i_s_dat  (s_rdat),
        .i_s_ack  (s_ack),
        .o_timeout(timeout)
    );

    // ---------------- scoreboard / model state ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] exp_q[$];       // expected ack codes {m1_ack, m0_ack}, in completion order
    int         owner  = -1;    // -1: bus free, else master index holding the bus
    int         last   = 1;     // master that completed most recently
    int         waited = 0;     // cycles the owner has waited without ack
    bit         pred_done;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare all outputs for the current inputs against the model.
    task automatic settle_check();
        logic [33:0] e_bus;
        logic [2:0]  e_ack;
        logic [31:0] e_dat;
        bit          own_cs, tout;
        #1;
        e_bus = '0;
        e_ack = '0;
        e_dat = {s_rdat, s_rdat};
        tout  = 1'b0;
        if (!rst && owner >= 0) begin
            own_cs = (owner == 1) ? m1_cs : m0_cs;
            tout   = TO_EN && own_cs && !s_ack && (waited == TIMEOUT - 1);
            if (owner == 1) e_bus = {own_cs && !tout, m1_we, m1_addr, m1_wdat};
            else            e_bus = {own_cs && !tout, m0_we, m0_addr, m0_wdat};
            if ((own_cs && s_ack) || tout) e_ack[owner] = 1'b1;
            e_ack[2] = tout;
            if (tout) e_dat[owner*16 +: 16] = 16'hDEAD;
        end
        pred_done = (e_ack[1:0] != 2'b00);
        check("bus", {30'd0, s_cs, s_we, s_addr, s_wdat}, {30'd0, e_bus});
        check("ack", {61'd0, timeout, m1_ack, m0_ack}, {61'd0, e_ack});
        check("rdat", {32'd0, m1_rdat, m0_rdat}, {32'd0, e_dat});
        if (pred_done) exp_q.push_back(e_ack[1:0]);
        if (m0_ack || m1_ack) begin
            if (exp_q.size() == 0) check("sb_spurious_ack", {62'd0, m1_ack, m0_ack}, 64'd0);
            else                   check("sb_ack_master", {62'd0, m1_ack, m0_ack}, {62'd0, exp_q.pop_front()});
        end
    endtask

    // Advance one clock and update the model with the rules of bus ownership.
    task automatic tick();
        bit own, other;
        @(posedge clk);
        if (rst) begin
            owner = -1; last = 1; waited = 0;
        end else if (owner < 0) begin
            if (m0_cs && m1_cs) owner = 1 - last;
            else if (m0_cs)     owner = 0;
            else if (m1_cs)     owner = 1;
            waited = 0;
        end else begin
            own   = (owner == 1) ? m1_cs : m0_cs;
            other = (owner == 1) ? m0_cs : m1_cs;
            if (pred_done) begin
                last   = owner;
                waited = 0;
                if (other)     owner = 1 - owner;
                else if (!own) owner = -1;
            end else if (!own) begin
                owner = -1; waited = 0;
            end else begin
                waited++;
            end
        end
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        settle_check();
        tick();
    endtask

    task automatic bus_idle(input int n);
        m0_cs = 0; m1_cs = 0; s_ack = 0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst = 1; m0_cs = 0; m1_cs = 0; s_ack = 0;
        settle_check();
        check("reset_quiet", {60'd0, s_cs, s_we, m0_ack, m1_ack}, 64'd0);
        tick();
        rst = 0;
    endtask

    task automatic rand_cycle();
        m0_cs   = m0_cs ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
        m1_cs   = m1_cs ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
        m0_addr = 16'($urandom); m1_addr = 16'($urandom);
        m0_wdat = 16'($urandom); m1_wdat = 16'($urandom);
        m0_we   = 1'($urandom);  m1_we   = 1'($urandom);
        s_rdat  = 16'($urandom);
        s_ack   = ($urandom_range(0, 2) == 0);
        rst     = ($urandom_range(0, 199) == 0);
        cycle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1; m0_addr = 0; m1_addr = 0; m0_wdat = 0; m1_wdat = 0;
        m0_we = 0; m1_we = 0; m0_cs = 0; m1_cs = 0; s_rdat = 0; s_ack = 0;
        do_reset();

        // 1: M0 read alone; ack in IDLE is ignored, data returned on grant+1.
        m0_cs = 1; m0_addr = 16'h0010; s_ack = 1; s_rdat = 16'h1234;
        settle_check();
        check("t1_idle", {62'd0, s_cs, m0_ack}, 64'd0);
        tick();
        s_ack = 0;
        settle_check();
        check("t1_grant", {47'd0, s_cs, s_addr}, {47'd0, 1'b1, 16'h0010});
        tick();
        s_ack = 1;
        settle_check();
        check("t1_ack", {46'd0, m0_ack, m1_ack, m0_rdat}, {46'd0, 1'b1, 1'b0, 16'h1234});
        tick();
        bus_idle(2);

        // 2: both request from reset -> M0 first, then strict alternation.
        do_reset();
        m0_cs = 1; m1_cs = 1; s_ack = 1;
        settle_check();
        tick();
        for (int i = 0; i < 4; i++) begin
            settle_check();
            check("t2_order", {62'd0, m1_ack, m0_ack}, (i % 2 == 0) ? 64'd1 : 64'd2);
            tick();
        end
        bus_idle(2);

        // 3: M1 write acked on its first granted cycle, exactly one ack.
        m1_cs = 1; m1_we = 1; m1_addr = 16'h8000; m1_wdat = 16'hBEEF; s_ack = 1;
        cycle();
        settle_check();
        check("t3_write", {30'd0, s_we, s_cs, s_addr, s_wdat}, {30'd0, 2'b11, 16'h8000, 16'hBEEF});
        check("t3_ack", {62'd0, m1_ack, m0_ack}, 64'd2);
        tick();
        m1_cs = 0;
        settle_check();
        check("t3_single_ack", {62'd0, m1_ack, m0_ack}, 64'd0);
        tick();
        m1_we = 0;
        bus_idle(2);

        // 4: M0 back-to-back transfers with no IDLE bubble.
        m0_cs = 1; s_ack = 0;
        cycle();
        s_ack = 1;
        for (int i = 0; i < 2; i++) begin
            settle_check();
            check("t4_b2b", {62'd0, s_cs, m0_ack}, 64'd3);
            tick();
        end
        s_ack = 0;
        settle_check();
        check("t4_still_cs", {63'd0, s_cs}, 64'd1);
        tick();
        bus_idle(2);

        // 5: reset in the middle of an M1 transfer.
        m1_cs = 1; m1_addr = 16'h5050;
        cycle();
        cycle();
        rst = 1; s_ack = 1;
        settle_check();
        check("t5_reset_gate", {61'd0, s_cs, m0_ack, m1_ack}, 64'd0);
        tick();
        rst = 0; s_ack = 0; m0_cs = 1; m0_addr = 16'h0A0A;
        settle_check();
        check("t5_idle_after", {63'd0, s_cs}, 64'd0);
        tick();
        settle_check();
        check("t5_m0_first", {47'd0, s_cs, s_addr}, {47'd0, 1'b1, 16'h0A0A});
        tick();
        bus_idle(2);

        // 6: slave never acks.
        m0_cs = 1; s_ack = 0;
        cycle();
`ifdef DCPU_ARB_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            settle_check();
            check("t6_wait", {61'd0, timeout, m0_ack, s_cs}, 64'd1);
            tick();
        end
        settle_check();
        check("t6_abort", {45'd0, timeout, m0_ack, s_cs, m0_rdat}, {45'd0, 3'b110, 16'hDEAD});
        tick();
        settle_check();
        check("t6_pulse", {63'd0, timeout}, 64'd0);
        tick();
`else
        for (int i = 0; i < 6; i++) begin
            settle_check();
            check("t6_stall", {61'd0, timeout, m0_ack, s_cs}, 64'd1);
            tick();
        end
`endif
        bus_idle(2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) rand_cycle();
        rst = 0;
        bus_idle(3);
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
